mura_mod_counter: RTL and testbench
===================================

MURA_MOD_COUNTER -- requirements
Module: mura_mod_counter

Interface
REQ-001 The block SHALL have the parameter: N, default 3, number of Moore states per channel (modulus); legal range 2..256.
REQ-002 The block SHALL have the parameter: CH, default 1, number of independent channels; legal range 1..16.
REQ-003 The block SHALL have the parameter: EDGE, default 0, where 0 means level mode (count every enabled cycle with a=1) and 1 means rising-edge mode.
REQ-004 The block SHALL have the derived constant: W = max(1, clog2(N)), state width.
REQ-005 The block SHALL have the port: clk  in  1  single clock, all logic on rising edge.
REQ-006 The block SHALL have the port: rst  in  1  reset, synchronous, active-high.
REQ-007 The block SHALL have the port: en  in  1  step enable, shared by all channels.
REQ-008 The block SHALL have the port: a  in  CH  per-channel count input.
REQ-009 The block SHALL have the port: dir  in  1  direction, 0 = up, 1 = down, shared.
REQ-010 The block SHALL have the port: load  in  CH  per-channel synchronous load strobe.
REQ-011 The block SHALL have the port: load_val  in  W  value loaded into every channel whose load bit is set.
REQ-012 The block SHALL have the port: state  out  CH*W  current state, channel i at bits [i*W +: W].
REQ-013 The block SHALL have the port: y  out  CH  registered Moore output, 1 when the channel state != 0.
REQ-014 The block SHALL have the port: wrap  out  CH  one-cycle pulse when the channel wraps.

Function
REQ-015 Each channel SHALL hold a state register s in 0..N-1, updated only on the rising clk edge.
REQ-016 In level mode, the step condition SHALL be en & a[i].
REQ-017 In edge mode, the step condition SHALL be en & a[i] & ~a_prev[i].
REQ-018 a_prev SHALL be sampled every cycle, regardless of en.
REQ-019 On a step with dir=0, s SHALL advance to s+1, and from N-1 to 0.
REQ-020 On a step with dir=1, s SHALL advance to s-1, and from 0 to N-1.
REQ-021 When neither a step nor a load occurs, s SHALL hold.
REQ-022 Priority SHALL be rst > load[i] > step.
REQ-023 A load SHALL be independent of en.
REQ-024 If load_val >= N, the loaded state SHALL be 0.
REQ-025 y[i] SHALL be registered and SHALL change on the same edge as s, so that y[i] == (state_i != 0) in every cycle with zero combinational delay from inputs.
REQ-026 wrap[i] SHALL be high for exactly the cycle after an edge on which a step crossed the N-1/0 boundary (either direction).
REQ-027 A load SHALL never assert wrap.
REQ-028 Latency SHALL be 1 cycle from the sampled inputs to state, y and wrap.
REQ-029 Channels SHALL be fully independent except for the shared en, dir and load_val.
REQ-030 With N not a power of two, unreachable encodings SHALL recover to 0 on the next clock edge.

Reset
REQ-031 While rst=1 at a clk edge, every s, y, wrap and a_prev SHALL be set to 0, with load and step ignored.
REQ-032 Reset asserted mid-count SHALL discard the pending step; counting SHALL resume from 0 on the first edge after rst falls.
REQ-033 Outputs SHALL be undefined only before the first clock edge with rst=1.

Structure
REQ-034 Package mura_pkg SHALL hold the localparams DIR_UP=0, DIR_DOWN=1, MODE_LEVEL=0 and MODE_EDGE=1, plus a function computing W from N.
REQ-035 The sub-module mura_channel SHALL contain one channel (state register, edge register, next-state, y and wrap logic), parametrised by N, W and EDGE.
REQ-036 The top level SHALL be a generate loop of CH instances of mura_channel plus output packing.
REQ-037 The block SHALL contain no latches, SHALL use a single clock domain, and SHALL have no asynchronous logic.

Verification
REQ-038 Scenario (N=3, EDGE=0, dir=0, en=1): a=1 held for 4 cycles after reset -> state 0,1,2,0,1; y 0,1,1,0,1; wrap high in exactly the cycle state returns to 0.
REQ-039 Scenario (N=3, dir=1, en=1, a=1): step from 0 -> state 2, y=1, wrap=1 for one cycle; with en=0, a toggling -> state unchanged.
REQ-040 Scenario (N=5, EDGE=1, en=1): a held high for 6 cycles -> exactly one step (state 1); three 1-cycle pulses -> state 4.
REQ-041 Scenario (N=5): load=1 with load_val=3 and a simultaneous step -> state 3, wrap=0; load_val=7 -> state 0, y=0.
REQ-042 Scenario (N=4, CH=2): a=2'b01 for 3 enabled cycles -> ch0=3, ch1=0; load=2'b10 with load_val=2 -> only ch1 changes.
REQ-043 Scenario: rst=1 asserted in the same cycle as a step at state N-1 -> next state 0, wrap=0, y=0; the first step after rst falls gives state 1.

Source files
------------

// File: rtl/mura_pkg.sv
// Shared constants and helpers for the mura modulo counter.
package mura_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int unsigned MODE_LEVEL = 0;
    localparam int unsigned MODE_EDGE  = 1;

    // State width for a modulus n, never narrower than one bit.
    function automatic int unsigned mura_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mura_channel.sv
// One modulo-N Moore counter channel: state, input edge register, y and wrap.
module mura_channel
    import mura_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned W    = mura_width(N),
    parameter int unsigned EDGE = MODE_LEVEL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         a,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state,
    output logic         y,
    output logic         wrap
);

    localparam int unsigned    WE    = W + 1;
    localparam logic [W-1:0]   S_MAX = W'(N - 1);

    logic         a_prev;
    logic         step;
    logic         load_ok;
    logic         state_ok;
    logic [W-1:0] s_next;
    logic         wrap_next;

    // Next-state selection: load beats step; illegal encodings fall back to 0.
    always_comb begin
        step      = en & a;
        load_ok   = WE'(load_val) < WE'(N);
        state_ok  = WE'(state) < WE'(N);
        s_next    = state;
        wrap_next = 1'b0;

        if (EDGE == MODE_EDGE) begin
            step = step & ~a_prev;
        end

        if (load) begin
            s_next = load_ok ? load_val : '0;
        end else if (!state_ok) begin
            s_next = '0;
        end else if (step) begin
            if (dir == DIR_DOWN) begin
                if (state == '0) begin
                    s_next    = S_MAX;
                    wrap_next = 1'b1;
                end else begin
                    s_next = state - W'(1);
                end
            end else begin
                if (state == S_MAX) begin
                    s_next    = '0;
                    wrap_next = 1'b1;
                end else begin
                    s_next = state + W'(1);
                end
            end
        end
    end

    // y is derived from s_next so it lands on the same edge as state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= '0;
            y      <= 1'b0;
            wrap   <= 1'b0;
            a_prev <= 1'b0;
        end else begin
            state  <= s_next;
            y      <= (s_next != '0);
            wrap   <= wrap_next;
            a_prev <= a;
        end
    end

endmodule

// File: rtl/mura_mod_counter.sv
// CH independent modulo-N counters sharing enable, direction and load value.
module mura_mod_counter
    import mura_pkg::*;
#(
    parameter  int unsigned N    = 3,
    parameter  int unsigned CH   = 1,
    parameter  int unsigned EDGE = MODE_LEVEL,
    localparam int unsigned W    = mura_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CH-1:0]   a,
    input  logic            dir,
    input  logic [CH-1:0]   load,
    input  logic [W-1:0]    load_val,
    output logic [CH*W-1:0] state,
    output logic [CH-1:0]   y,
    output logic [CH-1:0]   wrap
);

    // Elaboration-time guard on the parameter ranges.
    if (N < 2 || N > 256) begin : g_bad_n
        $error("mura_mod_counter: N out of range 2..256");
    end
    if (CH < 1 || CH > 16) begin : g_bad_ch
        $error("mura_mod_counter: CH out of range 1..16");
    end
    if (EDGE > MODE_EDGE) begin : g_bad_edge
        $error("mura_mod_counter: EDGE must be 0 or 1");
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        mura_channel #(
            .N    (N),
            .W    (W),
            .EDGE (EDGE)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .a        (a[i]),
            .dir      (dir),
            .load     (load[i]),
            .load_val (load_val),
            .state    (state[i*W +: W]),
            .y        (y[i]),
            .wrap     (wrap[i])
        );
    end

endmodule

// File: tb/tb_mura_mod_counter.sv
// Bench for mura_mod_counter: three configurations checked against an arithmetic model.
module tb_mura_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, dir;

    // d0: N=3 level, d1: N=5 edge, d2: N=4 level with two channels
    logic [0:0] a0, ld0, y0, w0;
    logic [1:0] lv0, st0;
    logic [0:0] a1, ld1, y1, w1;
    logic [2:0] lv1, st1;
    logic [1:0] a2, ld2, y2, w2;
    logic [1:0] lv2;
    logic [3:0] st2;

    mura_mod_counter #(.N(3), .CH(1), .EDGE(0)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .a(a0), .dir(dir), .load(ld0),
        .load_val(lv0), .state(st0), .y(y0), .wrap(w0));

    mura_mod_counter #(.N(5), .CH(1), .EDGE(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .a(a1), .dir(dir), .load(ld1),
        .load_val(lv1), .state(st1), .y(y1), .wrap(w1));

    mura_mod_counter #(.N(4), .CH(2), .EDGE(0)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .a(a2), .dir(dir), .load(ld2),
        .load_val(lv2), .state(st2), .y(y2), .wrap(w2));

    int total = 0;
    int bad   = 0;
    bit valid = 1'b0;

    int ms[3][2];
    int mw[3][2];
    int mp[3][2];

    function automatic int pn(input int d);
        case (d)
            0:       return 3;
            1:       return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int pe(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int pc(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    function automatic int get_a(input int d, input int c);
        case (d)
            0:       return int'(a0[0]);
            1:       return int'(a1[0]);
            default: return int'(a2[c]);
        endcase
    endfunction

    function automatic int get_ld(input int d, input int c);
        case (d)
            0:       return int'(ld0[0]);
            1:       return int'(ld1[0]);
            default: return int'(ld2[c]);
        endcase
    endfunction

    function automatic int get_lv(input int d);
        case (d)
            0:       return int'(lv0);
            1:       return int'(lv1);
            default: return int'(lv2);
        endcase
    endfunction

    function automatic int get_st(input int d, input int c);
        case (d)
            0:       return int'(st0);
            1:       return int'(st1);
            default: return (c == 0) ? int'(st2[1:0]) : int'(st2[3:2]);
        endcase
    endfunction

    function automatic int get_y(input int d, input int c);
        case (d)
            0:       return int'(y0[0]);
            1:       return int'(y1[0]);
            default: return int'(y2[c]);
        endcase
    endfunction

    function automatic int get_w(input int d, input int c);
        case (d)
            0:       return int'(w0[0]);
            1:       return int'(w1[0]);
            default: return int'(w2[c]);
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: modulo arithmetic applied at each rising edge.
    always @(posedge clk) begin : model
        int stp;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < pc(d); c++) begin
                if (rst) begin
                    ms[d][c] = 0;
                    mw[d][c] = 0;
                    mp[d][c] = 0;
                end else begin
                    stp = (en && get_a(d, c) != 0 && (pe(d) == 0 || mp[d][c] == 0)) ? 1 : 0;
                    mp[d][c] = get_a(d, c);
                    mw[d][c] = 0;
                    if (get_ld(d, c) != 0) begin
                        ms[d][c] = (get_lv(d) < pn(d)) ? get_lv(d) : 0;
                    end else if (stp != 0) begin
                        if (!dir) begin
                            mw[d][c] = (ms[d][c] == pn(d) - 1) ? 1 : 0;
                            ms[d][c] = (ms[d][c] + 1) % pn(d);
                        end else begin
                            mw[d][c] = (ms[d][c] == 0) ? 1 : 0;
                            ms[d][c] = (ms[d][c] + pn(d) - 1) % pn(d);
                        end
                    end
                end
            end
        end
        if (rst) valid = 1'b1;
    end

    // Every-cycle comparison of all channels against the model.
    always @(negedge clk) begin
        if (valid) begin
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < pc(d); c++) begin
                    check($sformatf("d%0d.ch%0d.state", d, c), get_st(d, c), ms[d][c]);
                    check($sformatf("d%0d.ch%0d.y", d, c), get_y(d, c), (ms[d][c] != 0) ? 1 : 0);
                    check($sformatf("d%0d.ch%0d.wrap", d, c), get_w(d, c), mw[d][c]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int es[4];
        int ew[4];
        es = '{1, 2, 0, 1};
        ew = '{0, 0, 1, 0};

        rst = 1'b1; en = 1'b0; dir = 1'b0;
        a0 = '0; ld0 = '0; lv0 = '0;
        a1 = '0; ld1 = '0; lv1 = '0;
        a2 = '0; ld2 = '0; lv2 = '0;
        tick();
        tick();
        check("reset.st0", int'(st0), 0);
        check("reset.y0", int'(y0), 0);
        check("reset.w0", int'(w0), 0);
        check("reset.st2", int'(st2), 0);
        rst = 1'b0;

        // level mode counting up through the wrap
        en = 1'b1;
        a0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("up%0d.st0", i), int'(st0), es[i]);
            check($sformatf("up%0d.y0", i), int'(y0), (es[i] != 0) ? 1 : 0);
            check($sformatf("up%0d.w0", i), int'(w0), ew[i]);
        end
        a0 = 1'b0;

        // down step from 0 wraps to N-1
        ld0 = 1'b1; lv0 = 2'd0;
        tick();
        ld0 = 1'b0;
        check("ld0.st0", int'(st0), 0);
        dir = 1'b1; a0 = 1'b1;
        tick();
        check("down.st0", int'(st0), 2);
        check("down.y0", int'(y0), 1);
        check("down.w0", int'(w0), 1);
        a0 = 1'b0;
        tick();
        check("down.w0_clear", int'(w0), 0);
        check("down.st0_hold", int'(st0), 2);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a0 = ~a0;
            tick();
        end
        check("en0.st0", int'(st0), 2);
        a0 = 1'b0; en = 1'b1; dir = 1'b0;

        // edge mode: held input steps once, pulses step each time
        a1 = 1'b1;
        repeat (6) tick();
        check("edge.held.st1", int'(st1), 1);
        a1 = 1'b0;
        tick();
        repeat (3) begin
            a1 = 1'b1; tick();
            a1 = 1'b0; tick();
        end
        check("edge.pulses.st1", int'(st1), 4);

        // load overrides a step that would have wrapped, out-of-range load gives 0
        ld1 = 1'b1; lv1 = 3'd3; a1 = 1'b1;
        tick();
        check("load.st1", int'(st1), 3);
        check("load.w1", int'(w1), 0);
        lv1 = 3'd7; a1 = 1'b0;
        tick();
        check("load7.st1", int'(st1), 0);
        check("load7.y1", int'(y1), 0);
        ld1 = 1'b0;

        // two channels are independent
        a2 = 2'b01;
        repeat (3) tick();
        check("ch.ch0", int'(st2[1:0]), 3);
        check("ch.ch1", int'(st2[3:2]), 0);
        a2 = 2'b00; ld2 = 2'b10; lv2 = 2'd2;
        tick();
        check("ch.ld.ch0", int'(st2[1:0]), 3);
        check("ch.ld.ch1", int'(st2[3:2]), 2);
        en = 1'b0; ld2 = 2'b01; lv2 = 2'd1;
        tick();
        check("ch.ld_noen.ch0", int'(st2[1:0]), 1);
        ld2 = 2'b00; en = 1'b1;
        dir = 1'b1; a2 = 2'b11;
        tick();
        tick();
        check("ch.down.ch0", int'(st2[1:0]), 3);
        check("ch.down.w0", int'(w2[0]), 1);
        check("ch.down.ch1", int'(st2[3:2]), 0);
        check("ch.down.w1", int'(w2[1]), 0);
        a2 = 2'b00; dir = 1'b0;

        // reset beats a wrapping step, counting resumes from 0
        a0 = 1'b1; rst = 1'b1;
        tick();
        check("rst.st0", int'(st0), 0);
        check("rst.w0", int'(w0), 0);
        check("rst.y0", int'(y0), 0);
        rst = 1'b0;
        tick();
        check("rst.resume.st0", int'(st0), 1);
        a0 = 1'b0;

        // mixed directed pattern, checked by the per-cycle compare
        for (int i = 0; i < 24; i++) begin
            en  = (i % 5 != 4);
            dir = ((i / 8) % 2) != 0;
            a0  = 1'(i % 2);
            a1  = 1'(i % 3 == 0);
            a2  = 2'(i);
            ld1 = 1'(i == 13);
            lv1 = 3'(i);
            ld2 = (i == 17) ? 2'b01 : 2'b00;
            lv2 = 2'(i);
            tick();
        end
        ld1 = '0; ld2 = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
